// File: rtl/resetn_drive.sv
// resetn_drive: drives an active-low external reset pin with pulses of a
// guaranteed low width followed by a guaranteed high recovery gap. Pulses
// come from module reset, a single-cycle request, or an idle-time watchdog.
module resetn_drive #(
  parameter int unsigned PULSE_WIDTH = 16,
  parameter int unsigned RECOVER     = 16,
  parameter int unsigned WD_WIDTH    = 20
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_req,
  input  logic i_wd_enable,
  input  logic i_wd_kick,
  input  logic i_wd_clear,
  output logic o_resetn_pin,
  output logic o_busy,
  output logic o_wd_fired
);

  // The phase counter is shared by the low phase and the recovery phase.
  localparam int unsigned CNT_MAX = (PULSE_WIDTH > RECOVER) ? PULSE_WIDTH : RECOVER;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RECOVER - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [WD_WIDTH-1:0]   r_wd_cnt;
  logic                  r_resetn_pin;
  logic                  r_busy;
  logic                  r_wd_fired;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [WD_WIDTH-1:0]   w_wd_cnt_nxt;
  logic                  w_resetn_pin_nxt;
  logic                  w_busy_nxt;
  logic                  w_wd_fired_nxt;
  logic                  w_expire;

  // Watchdog expiry: count saturated in IDLE while enabled and not being kicked.
  assign w_expire = (r_state == S_IDLE) && i_wd_enable && !i_wd_kick && (&r_wd_cnt);

  // State, counters and output flops; reset starts a full pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_ASSERT;
      r_cnt        <= '0;
      r_wd_cnt     <= '0;
      r_resetn_pin <= 1'b0;
      r_busy       <= 1'b1;
      r_wd_fired   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wd_cnt     <= w_wd_cnt_nxt;
      r_resetn_pin <= w_resetn_pin_nxt;
      r_busy       <= w_busy_nxt;
      r_wd_fired   <= w_wd_fired_nxt;
    end
  end

  // Next state, counters and next output values (outputs follow next state).
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_wd_cnt_nxt     = r_wd_cnt;
    w_wd_fired_nxt   = r_wd_fired;
    w_resetn_pin_nxt = 1'b1;
    w_busy_nxt       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // Requests are only honoured here; elsewhere they are dropped.
        if (i_req || w_expire) begin
          w_state_nxt = S_ASSERT;
          w_cnt_nxt   = '0;
        end
      end
      S_ASSERT: begin
        if (r_cnt == PW_LAST) begin
          w_state_nxt = S_RECOVER;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RECOVER: begin
        if (r_cnt == RC_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Watchdog only counts enabled, unkicked IDLE cycles; expiry wraps it to zero.
    if ((r_state != S_IDLE) || !i_wd_enable || i_wd_kick) begin
      w_wd_cnt_nxt = '0;
    end else begin
      w_wd_cnt_nxt = r_wd_cnt + WD_WIDTH'(1);
    end

    // Sticky cause flag: a simultaneous expiry beats a clear.
    if (w_expire) begin
      w_wd_fired_nxt = 1'b1;
    end else if (i_wd_clear) begin
      w_wd_fired_nxt = 1'b0;
    end

    w_resetn_pin_nxt = (w_state_nxt != S_ASSERT);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
  end

  assign o_resetn_pin = r_resetn_pin;
  assign o_busy       = r_busy;
  assign o_wd_fired   = r_wd_fired;

endmodule

// File: doc/resetn_drive.md
# resetn_drive

Drives an external active-low reset pin, the transmitting counterpart of the board's input reset synchronizer. It produces clean, registered reset pulses of guaranteed minimum width, followed by a guaranteed recovery gap. Pulses come from module reset, a software request, or a built-in watchdog. It sits in the system clock domain and feeds the reset input of a downstream FPGA or peripheral.

## Interface
- PULSE_WIDTH, default 16: cycles the pin is held low per pulse; must be ≥ 1.
- RECOVER, default 16: cycles the pin stays high after a pulse before a new pulse may start; must be ≥ 1.
- WD_WIDTH, default 20: watchdog counter width; timeout is 2^WD_WIDTH idle cycles.
- clock  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high.
- req  in  1  single-cycle request for a reset pulse.
- wd_enable  in  1  enables the watchdog while high.
- wd_kick  in  1  restarts the watchdog count.
- wd_clear  in  1  clears wd_fired.
- resetn_pin  out  1  external reset; active low, driven directly from a flop.
- busy  out  1  high during the ASSERT and RECOVER states.
- wd_fired  out  1  sticky flag: the most recent uncleared pulse cause included a watchdog expiry.

## Operation
- The FSM has three states: IDLE, ASSERT and RECOVER, plus a shared counter `cnt` of width clog2(max(PULSE_WIDTH, RECOVER)).
- Module reset (reset=1):
  - forces state=ASSERT and cnt=0.
  - forces resetn_pin=0, busy=1 and wd_fired=0.
  - clears the watchdog count.
  - After reset falls, a full PULSE_WIDTH pulse follows, so a power-on reset propagates to the pin.
- IDLE: resetn_pin=1, busy=0. If req=1 or the watchdog expires, go to ASSERT with cnt=0.
- ASSERT: resetn_pin=0, busy=1, cnt increments. When cnt==PULSE_WIDTH-1, go to RECOVER with cnt=0.
- RECOVER: resetn_pin=1, busy=1, cnt increments. When cnt==RECOVER-1, go to IDLE.
- req outside IDLE is dropped; it is never queued.
- Watchdog:
  - wd_cnt (WD_WIDTH bits) increments each cycle while the state is IDLE and wd_enable=1.
  - wd_cnt is cleared on wd_kick, when wd_enable=0, and in any non-IDLE state.
  - Expiry means wd_cnt is all ones, the state is IDLE, wd_enable=1 and wd_kick=0 in the same cycle.
- wd_fired is set on expiry and cleared by wd_clear.
- Simultaneous events:
  - wd_kick and would-be expiry in the same cycle: the kick wins, there is no pulse, and wd_cnt becomes 0.
  - req and expiry in the same cycle: exactly one pulse, and wd_fired is set.
  - wd_clear and expiry in the same cycle: wd_fired ends at 1 (set wins).
  - reset asserted mid-ASSERT or mid-RECOVER: the full pulse restarts from cnt=0 after reset falls.

## Timing
- Every output is registered; no combinational path from any input to any output.
- req sampled at edge N: resetn_pin=0 and busy=1 from edge N for exactly PULSE_WIDTH cycles.
- resetn_pin then returns to 1. busy stays 1 for RECOVER more cycles, so busy is high for PULSE_WIDTH+RECOVER cycles in total.
- The earliest next accepted req is in the first cycle with busy=0.
- Watchdog timeout: with no kicks, expiry occurs in the 2^WD_WIDTH-th consecutive enabled IDLE cycle. The pin falls at the following edge. wd_fired rises at the same edge as the pin.
- Minimum low time and minimum high gap are guaranteed for every pulse, including pulses caused by module reset.

## Test plan
All scenarios use PULSE_WIDTH=4, RECOVER=3, WD_WIDTH=4 unless stated.

1. Hold reset for 2 cycles, then release. Required: resetn_pin=0 during reset and for 4 cycles after; busy=1 for 3 further cycles, then busy=0 with the pin at 1.
2. Pulse req for 1 cycle in IDLE. Required: pin low for exactly 4 cycles starting the next cycle; busy high for exactly 7 cycles; wd_fired stays 0.
3. Pulse req during ASSERT and again in the last RECOVER cycle. Required: both are ignored, with no extra low cycles. A req in the first busy=0 cycle produces a new 4-cycle pulse.
4. Set wd_enable=1 with no kicks. Required: a pulse starts 16 IDLE cycles after entering IDLE, and wd_fired=1. Repeat with wd_kick every 10 cycles over 200 cycles. Required: no pulse.
5. Assert wd_kick in the expiry cycle. Required: no pulse. Assert wd_clear in an expiry cycle. Required: wd_fired=1. Assert req in an expiry cycle. Required: one 4-cycle pulse.
6. Assert reset during the 3rd ASSERT cycle, hold it 1 cycle, then release. Required: the pin stays low continuously and goes high only after 4 full post-reset low cycles; wd_fired=0.
